// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch (I)
// and data access (D). One transaction in flight at a time, with a response timeout.
module mem_port_arbiter #(
   parameter int WORD     = 32,
   parameter int ADDR_LEN = 32,
   parameter int TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                if_req_valid,
   input  logic [ADDR_LEN-1:0] if_req_addr,
   output logic                if_req_ready,
   output logic                if_resp_valid,
   output logic [WORD-1:0]     if_resp_data,
   output logic                if_resp_err,

   input  logic                d_req_valid,
   input  logic                d_req_we,
   input  logic [ADDR_LEN-1:0] d_req_addr,
   input  logic [WORD-1:0]     d_req_wdata,
   output logic                d_req_ready,
   output logic                d_resp_valid,
   output logic [WORD-1:0]     d_resp_data,
   output logic                d_resp_err,

   output logic                mem_req_valid,
   output logic                mem_req_we,
   output logic [ADDR_LEN-1:0] mem_req_addr,
   output logic [WORD-1:0]     mem_req_wdata,
   input  logic                mem_req_ready,
   input  logic                mem_resp_valid,
   input  logic [WORD-1:0]     mem_resp_data,

   output logic                busy
);

   localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
   localparam bit               TO_EN    = (TIMEOUT != 0);

   logic [1:0]          r_state;
   logic                r_lastGrant;
   logic                r_owner;
   logic                r_we;
   logic [ADDR_LEN-1:0] r_addr;
   logic [WORD-1:0]     r_wdata;
   logic [CNT_W-1:0]    r_cnt;

   logic                r_ifRespValid;
   logic                r_ifRespErr;
   logic [WORD-1:0]     r_ifRespData;
   logic                r_dRespValid;
   logic                r_dRespErr;
   logic [WORD-1:0]     r_dRespData;

   logic                w_grantI;
   logic                w_grantD;
   logic                w_idle;
   logic                w_accept;
   logic                w_timeoutHit;
   logic                w_finish;
   logic [WORD-1:0]     w_respData;

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      w_grantD = d_req_valid & (~if_req_valid | (r_lastGrant == OWN_I));
      w_grantI = if_req_valid & ~w_grantD;
   end

   // Readies are gated by reset so they stay low while reset is held.
   assign w_idle       = reset & (r_state == IDLE);
   assign if_req_ready = w_idle & w_grantI;
   assign d_req_ready  = w_idle & w_grantD;
   assign w_accept     = if_req_ready | d_req_ready;

   assign w_timeoutHit = TO_EN && (r_cnt == CNT_LAST);
   assign w_finish     = (r_state == WAIT) && (mem_resp_valid || w_timeoutHit);
   assign w_respData   = (mem_resp_valid && !r_we) ? mem_resp_data : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_lastGrant <= OWN_D;
         r_owner     <= OWN_I;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_owner     <= w_grantD ? OWN_D : OWN_I;
                  r_lastGrant <= w_grantD ? OWN_D : OWN_I;
                  r_we        <= w_grantD & d_req_we;
                  r_addr      <= w_grantD ? d_req_addr : if_req_addr;
                  r_wdata     <= w_grantD ? d_req_wdata : '0;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_finish) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Counter saturates rather than wrapping so a disabled timeout never fires.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (r_state == ISSUE) begin
         r_cnt <= '0;
      end else if (r_state == WAIT && r_cnt != CNT_MAX) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A memory response wins over a timeout firing in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ifRespValid <= 1'b0;
         r_ifRespErr   <= 1'b0;
         r_ifRespData  <= '0;
         r_dRespValid  <= 1'b0;
         r_dRespErr    <= 1'b0;
         r_dRespData   <= '0;
      end else begin
         r_ifRespValid <= 1'b0;
         r_ifRespErr   <= 1'b0;
         r_dRespValid  <= 1'b0;
         r_dRespErr    <= 1'b0;
         if (w_finish) begin
            if (r_owner == OWN_D) begin
               r_dRespValid <= 1'b1;
               r_dRespErr   <= ~mem_resp_valid;
               r_dRespData  <= w_respData;
            end else begin
               r_ifRespValid <= 1'b1;
               r_ifRespErr   <= ~mem_resp_valid;
               r_ifRespData  <= w_respData;
            end
         end
      end
   end

   assign mem_req_valid = (r_state == ISSUE);
   assign mem_req_we    = r_we;
   assign mem_req_addr  = r_addr;
   assign mem_req_wdata = r_wdata;

   assign if_resp_valid = r_ifRespValid;
   assign if_resp_err   = r_ifRespErr;
   assign if_resp_data  = r_ifRespData;
   assign d_resp_valid  = r_dRespValid;
   assign d_resp_err    = r_dRespErr;
   assign d_resp_data   = r_dRespData;

   assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model answers requests and
// every accepted request queues its expected response, beat and arrival cycle.
module tb_mem_port_arbiter;

   localparam int WORD     = 32;
   localparam int ADDR_LEN = 32;
   localparam int TIMEOUT  = 8;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
   logic [ADDR_LEN-1:0] if_req_addr;
   logic [WORD-1:0]     if_resp_data;
   logic                d_req_valid, d_req_we, d_req_ready, d_resp_valid, d_resp_err;
   logic [ADDR_LEN-1:0] d_req_addr;
   logic [WORD-1:0]     d_req_wdata, d_resp_data;
   logic                mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;
   logic [ADDR_LEN-1:0] mem_req_addr;
   logic [WORD-1:0]     mem_req_wdata, mem_resp_data;
   logic                busy;

   mem_port_arbiter #(.WORD(WORD), .ADDR_LEN(ADDR_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid),
      .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] data;
      int          cyc;
   } respExp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } memExp_t;

   respExp_t    respQ[$];
   memExp_t     memQ[$];
   logic        grantLog[$];
   logic [31:0] memStore[logic [31:0]];

   int checkCount = 0;
   int errorCount = 0;
   int hsCount = 0;
   int readyDelay = 0;
   int respDelay = 0;
   int modelPhase = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (memStore.exists(a)) return memStore[a];
      return a ^ 32'hCAFE_0000;
   endfunction

   // Expected outcome is fixed when the request is accepted, from the memory timing in force.
   task automatic pushReq(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      respExp_t r;
      memExp_t  m;
      logic     timedOut;
      timedOut = (respDelay >= TIMEOUT);
      r.port = port;
      r.err  = timedOut;
      r.data = (timedOut || we) ? 32'h0 : memRead(addr);
      r.cyc  = cyc + 2 + readyDelay + (timedOut ? TIMEOUT : respDelay + 1);
      m.we    = we;
      m.addr  = addr;
      m.wdata = wdata;
      respQ.push_back(r);
      memQ.push_back(m);
      grantLog.push_back(port);
      hsCount++;
   endtask

   task automatic checkResp(input logic port, input logic valid, input logic err, input logic [31:0] data);
      respExp_t r;
      if (respQ.size() == 0) begin
         checkOutput("respUnexpected", valid, 1'b0);
      end else begin
         r = respQ.pop_front();
         checkOutput("respPort", port, r.port);
         checkOutput("respErr", err, r.err);
         checkOutput("respData", data, r.data);
         checkOutput("respCycle", cyc, r.cyc);
      end
   endtask

   // Memory model: holds ready low for readyDelay cycles, answers respDelay cycles into WAIT.
   initial begin : memModel
      int          rdyCnt;
      int          waitCnt;
      logic        curWe;
      logic [31:0] curAddr;
      rdyCnt = 0; waitCnt = 0; curWe = 1'b0; curAddr = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      forever begin
         @(posedge clk); #1;
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         mem_resp_data  = '0;
         if (!reset) begin
            modelPhase = 0;
            rdyCnt = 0;
         end else if (modelPhase == 0) begin
            if (mem_req_valid) begin
               if (rdyCnt >= readyDelay) begin
                  mem_req_ready = 1'b1;
                  curWe   = mem_req_we;
                  curAddr = mem_req_addr;
                  if (mem_req_we) memStore[mem_req_addr] = mem_req_wdata;
                  rdyCnt = 0;
                  waitCnt = 0;
                  modelPhase = 1;
               end else begin
                  rdyCnt++;
               end
            end
         end else begin
            if (waitCnt == respDelay) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = curWe ? 32'hFFFF_FFFF : memRead(curAddr);
               modelPhase = 0;
            end
            waitCnt++;
         end
      end
   end

   initial begin : monitor
      memExp_t m;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (if_req_valid && if_req_ready) pushReq(1'b0, 1'b0, if_req_addr, 32'h0);
            if (d_req_valid && d_req_ready) pushReq(1'b1, d_req_we, d_req_addr, d_req_wdata);
            if (mem_req_valid && mem_req_ready) begin
               if (memQ.size() == 0) begin
                  checkOutput("memUnexpected", mem_req_ready, 1'b0);
               end else begin
                  m = memQ.pop_front();
                  checkOutput("memWe", mem_req_we, m.we);
                  checkOutput("memAddr", mem_req_addr, m.addr);
                  checkOutput("memWdata", mem_req_wdata, m.wdata);
               end
            end
            if (if_resp_valid) checkResp(1'b0, if_resp_valid, if_resp_err, if_resp_data);
            if (d_resp_valid) checkResp(1'b1, d_resp_valid, d_resp_err, d_resp_data);
         end
      end
   end

   task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      int start;
      start = hsCount;
      if (port) begin
         d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
      end else begin
         if_req_valid = 1'b1; if_req_addr = addr;
      end
      for (int i = 0; i < 60 && hsCount == start; i++) begin
         @(posedge clk); #1;
      end
      if (hsCount == start) checkOutput("hsTimeout", hsCount, start + 1);
      if (port) d_req_valid = 1'b0;
      else if_req_valid = 1'b0;
   endtask

   task automatic waitIdle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk); #2;
         done = !busy && modelPhase == 0 && respQ.size() == 0;
      end
      if (!done) checkOutput("idleTimeout", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic waitGrants(input int n);
      for (int i = 0; i < 80 && grantLog.size() < n; i++) begin
         @(posedge clk); #1;
      end
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
      checkOutput("grantCount", grantLog.size(), n);
   endtask

   initial begin : main
      bit found;
      int target;
      if_req_valid = 1'b0; if_req_addr = '0;
      d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;

      // Reset held with random request inputs
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if_req_valid = 1'($urandom_range(0, 1));
         if_req_addr  = $urandom;
         d_req_valid  = 1'($urandom_range(0, 1));
         d_req_we     = 1'($urandom_range(0, 1));
         d_req_addr   = $urandom;
         d_req_wdata  = $urandom;
         @(negedge clk);
         checkOutput("rstReady", {if_req_ready, d_req_ready}, 2'b00);
         checkOutput("rstMemReq", {mem_req_valid, mem_req_we, |mem_req_addr, |mem_req_wdata}, 4'h0);
         checkOutput("rstResp", {if_resp_valid, if_resp_err, |if_resp_data,
                                 d_resp_valid, d_resp_err, |d_resp_data}, 6'h0);
         checkOutput("rstBusy", busy, 1'b0);
      end

      // Single fetch read right after release, memory answering immediately
      @(posedge clk); #1;
      memStore[32'h100] = 32'hDEADBEEF;
      d_req_valid = 1'b0;
      if_req_valid = 1'b1; if_req_addr = 32'h100;
      readyDelay = 0; respDelay = 0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("c0IfReady", if_req_ready, 1'b1);
      checkOutput("c0DReady", d_req_ready, 1'b0);
      @(posedge clk); #1;
      if_req_valid = 1'b0;
      @(negedge clk);
      checkOutput("c1MemValid", mem_req_valid, 1'b1);
      checkOutput("c1MemAddr", mem_req_addr, 32'h100);
      checkOutput("c1MemWe", mem_req_we, 1'b0);
      @(negedge clk);
      checkOutput("c2MemValid", mem_req_valid, 1'b0);
      checkOutput("c2Busy", busy, 1'b1);
      @(negedge clk);
      checkOutput("c3IfResp", {if_resp_valid, if_resp_err}, 2'b10);
      checkOutput("c3IfData", if_resp_data, 32'hDEADBEEF);
      checkOutput("c3DResp", d_resp_valid, 1'b0);
      waitIdle();

      // Reset pulse, then round-robin with both ports always requesting
      reset = 1'b0;
      respQ.delete(); memQ.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      grantLog.delete();
      if_req_valid = 1'b1; if_req_addr = 32'h300;
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h200; d_req_wdata = 32'h55;
      waitGrants(4);
      for (int i = 0; i < 4 && i < grantLog.size(); i++)
         checkOutput($sformatf("rrGrant%0d", i), grantLog[i], i % 2);
      waitIdle();

      // Backpressure: memory holds ready low for 5 cycles
      readyDelay = 5; respDelay = 1;
      applyStimulus(1'b1, 1'b1, 32'h400, 32'h1234);
      if_req_valid = 1'b1; if_req_addr = 32'h400;
      target = hsCount + 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("bpMemValid", mem_req_valid, 1'b1);
         checkOutput("bpMemAddr", mem_req_addr, 32'h400);
         checkOutput("bpMemWdata", mem_req_wdata, 32'h1234);
         checkOutput("bpReadies", {if_req_ready, d_req_ready}, 2'b00);
         checkOutput("bpBusy", busy, 1'b1);
      end
      for (int i = 0; i < 60 && hsCount < target; i++) begin
         @(posedge clk); #1;
      end
      if_req_valid = 1'b0;
      checkOutput("bpIfAccepted", hsCount, target);
      waitIdle();

      // Timeout on a D read, followed by a late response that must be ignored
      readyDelay = 0; respDelay = TIMEOUT + 2;
      applyStimulus(1'b1, 1'b0, 32'h500, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         found = d_resp_valid;
      end
      checkOutput("toResp", d_resp_valid, 1'b1);
      checkOutput("toErr", d_resp_err, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("lateIgnored", {if_resp_valid, d_resp_valid}, 2'b00);
         checkOutput("lateIdle", busy, 1'b0);
      end
      waitIdle();
      respDelay = 0;
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0);
      waitIdle();

      // Response in the cycle the timeout fires wins; one cycle later it is too late
      respDelay = TIMEOUT - 1;
      applyStimulus(1'b1, 1'b0, 32'h200, 32'h0);
      waitIdle();
      respDelay = TIMEOUT;
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0);
      waitIdle();

      // Reset during WAIT drops the transaction
      respDelay = 6;
      applyStimulus(1'b0, 1'b0, 32'h300, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      respQ.delete(); memQ.delete();
      #1;
      checkOutput("midRstBusy", busy, 1'b0);
      checkOutput("midRstMem", {mem_req_valid, mem_req_we, |mem_req_addr}, 3'h0);
      checkOutput("midRstResp", {if_resp_valid, |if_resp_data, d_resp_valid, |d_resp_data}, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("midRstHold", {if_resp_valid, d_resp_valid, busy}, 3'b000);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      grantLog.delete();
      respDelay = 0;
      if_req_valid = 1'b1; if_req_addr = 32'h200;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h100;
      waitGrants(2);
      for (int i = 0; i < 2 && i < grantLog.size(); i++)
         checkOutput($sformatf("postRstGrant%0d", i), grantLog[i], i % 2);
      waitIdle();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory interface between two requesters: instruction fetch (port I) and data access (port D).
- Round-robin arbitration; one transaction outstanding at a time.
- Per-transaction response timeout.
- Sits between instructfetch/dcache-side logic and the backing memory model.

Parameters:
WORD, 32, data width of read/write data
ADDR_LEN, 32, address width
TIMEOUT, 16, cycles to wait for a memory response before returning an error; 0 disables the timeout

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
if_req_valid  input  1  fetch read request
if_req_addr  input  ADDR_LEN  fetch address
if_req_ready  output  1  fetch request accepted this cycle
if_resp_valid  output  1  fetch response pulse, one cycle
if_resp_data  output  WORD  fetch read data
if_resp_err  output  1  fetch response is a timeout error
d_req_valid  input  1  data request
d_req_we  input  1  1=write, 0=read
d_req_addr  input  ADDR_LEN  data address
d_req_wdata  input  WORD  write data
d_req_ready  output  1  data request accepted this cycle
d_resp_valid  output  1  data response pulse, one cycle
d_resp_data  output  WORD  data read data (0 for writes)
d_resp_err  output  1  data response is a timeout error
mem_req_valid  output  1  request to memory
mem_req_we  output  1  write enable to memory
mem_req_addr  output  ADDR_LEN  memory address
mem_req_wdata  output  WORD  memory write data
mem_req_ready  input  1  memory accepts request
mem_resp_valid  input  1  memory response (read data or write ack)
mem_resp_data  input  WORD  memory read data
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; last_grant=D; timeout counter=0; latched request=0.
  - All outputs 0.
  - An in-flight transaction is dropped; no response is generated for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE arbitration:
  - Winner selected combinationally. Only one valid: that port wins. Both valid: the port not equal to last_grant wins.
  - Only the winner's req_ready=1; both readies are 0 in ISSUE and WAIT.
  - On valid&ready: latch owner, we (0 for I), addr, wdata (0 for I); set last_grant=owner; go to ISSUE.
  - Dropping valid before ready is legal and has no effect.
- ISSUE:
  - mem_req_valid=1, driven from the latched fields, held stable until mem_req_ready.
  - On mem_req_ready: go to WAIT; counter=0.
- WAIT:
  - mem_req_valid=0; counter increments each cycle.
  - On mem_resp_valid: next cycle, owner's resp_valid=1, resp_err=0, resp_data=mem_resp_data (D writes: data=0); go to IDLE.
  - No response and TIMEOUT!=0 and counter==TIMEOUT-1: next cycle, owner's resp_valid=1, resp_err=1, resp_data=0; go to IDLE.
  - A response arriving in the same cycle the timeout fires takes precedence, so err=0.
- mem_resp_valid in IDLE or ISSUE is ignored. This covers stale or late responses after a timeout.
- Response outputs are registered. resp_valid and resp_err clear after one cycle; resp_data holds until the next response.
- The non-owner port never sees resp_valid.
- Latency with memory ready immediately and a same-cycle response:
  - Request accepted in cycle 0, mem_req_valid in cycle 1, WAIT in cycle 2, mem_resp_valid in cycle 2 at earliest, resp_valid in cycle 3.
  - A new request can be accepted in cycle 3, giving a 3-cycle throughput.
- Counter width is $clog2(TIMEOUT+1), minimum 1. It saturates and does not wrap when TIMEOUT=0.
- busy=1 in ISSUE and WAIT.

Test Plan:
- Reset check: hold reset=0 with random inputs -> all outputs 0, busy=0; release -> first handshake available the next cycle.
- Single fetch read: if_req_valid=1 with addr 0x100; memory ready immediately and returns 0xDEADBEEF one cycle into WAIT -> if_req_ready in cycle 0, mem_req_addr=0x100 with we=0 in cycle 1, if_resp_valid=1 with data 0xDEADBEEF and err=0 in cycle 3, d_resp_valid stays 0.
- Round-robin: both ports continuously valid after reset (D write 0x200/0x55) -> grant order I, D, I, D over 4 transactions; the D transaction drives mem_req_we=1 and wdata=0x55; d_resp_data=0.
- Backpressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid, mem_req_addr and mem_req_wdata stable for all 6 cycles; both req_ready signals 0; busy=1.
- Timeout: D read with no mem_resp_valid -> d_resp_valid=1 with err=1 and data 0 exactly TIMEOUT cycles after entering WAIT; a late mem_resp_valid 2 cycles later produces no response; the next I request completes normally.
- Reset mid-WAIT: assert reset during WAIT -> outputs 0 immediately, no response pulse; after release a fetch completes with correct data and round-robin restarts with I winning a tie.
